lsu_mem_stage: RTL

- Load/store unit directly downstream of the RV32I ALU in the uniciclo core.
- Consumes the ALU effective address together with opcode, func3 and the rs2 value.
- Drives a req/ack data-memory port, stalls the core while an access is outstanding, and returns the aligned, sign/zero-extended load result to the writeback mux.

---
 rtl/lsu_mem_stage.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_stage.sv
// RV32I load/store unit between the ALU and writeback: drives a req/ack data port,
// stalls the core while busy and formats load results. Optional: LSU_MISALIGN_TRAP_EN.
module lsu_mem_stage #(
   parameter int WIDTH = 32,
   parameter int BE_W  = WIDTH/8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid,
   input  logic [6:0]       opcode,
   input  logic [2:0]       func3,
   input  logic [WIDTH-1:0] addr,
   input  logic [WIDTH-1:0] store_data,
   output logic             stall,
   output logic [WIDTH-1:0] load_data,
   output logic             load_valid,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [BE_W-1:0]  mem_be,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic             mem_ack,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic             misalign_trap
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

   state_t           r_state;
   state_t           w_state_next;

   logic             w_is_load;
   logic             w_is_store;
   logic             w_is_mem;
   logic             w_misalign;
   logic [BE_W-1:0]  w_be;
   logic [WIDTH-1:0] w_wdata;

   logic [WIDTH-1:0] r_mem_addr;
   logic             r_mem_we;
   logic [BE_W-1:0]  r_mem_be;
   logic [WIDTH-1:0] r_mem_wdata;
   logic [1:0]       r_off;
   logic [2:0]       r_func3;
   logic             r_is_load;
   logic             r_trap;
   logic [WIDTH-1:0] r_load_data;

   assign w_is_load  = valid & (opcode == OP_LOAD);
   assign w_is_store = valid & (opcode == OP_STORE);
   assign w_is_mem   = w_is_load | w_is_store;

   // Lane selection and sign/zero extension of the returned word.
   function automatic logic [31:0] fmt_load(input logic [31:0] rdata,
                                            input logic [1:0]  off,
                                            input logic [2:0]  f3);
      logic [7:0]  b;
      logic [15:0] h;
      b = rdata[{off, 3'b000} +: 8];
      h = off[1] ? rdata[31:16] : rdata[15:0];
      case (f3)
         3'b000:  fmt_load = {{24{b[7]}}, b};
         3'b100:  fmt_load = {24'd0, b};
         3'b001:  fmt_load = {{16{h[15]}}, h};
         3'b101:  fmt_load = {16'd0, h};
         default: fmt_load = rdata;
      endcase
   endfunction

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = store_data;
      if (w_is_store) begin
         case (func3)
            3'b000: begin
               w_be    = 4'b0001 << addr[1:0];
               w_wdata = {4{store_data[7:0]}};
            end
            3'b001: begin
               w_be    = addr[1] ? 4'b1100 : 4'b0011;
               w_wdata = {2{store_data[15:0]}};
            end
            default: begin
               w_be    = 4'b1111;
               w_wdata = store_data;
            end
         endcase
      end
   end

`ifdef LSU_MISALIGN_TRAP_EN
   // Loads use func3[1:0] for size; stores treat every code but 000/001 as a word.
   always_comb begin
      w_misalign = 1'b0;
      if (w_is_load) begin
         case (func3[1:0])
            2'b00:   w_misalign = 1'b0;
            2'b01:   w_misalign = addr[0];
            default: w_misalign = |addr[1:0];
         endcase
      end else if (w_is_store) begin
         case (func3)
            3'b000:  w_misalign = 1'b0;
            3'b001:  w_misalign = addr[0];
            default: w_misalign = |addr[1:0];
         endcase
      end
   end
   assign misalign_trap = (r_state == DONE) & r_trap;
`else
   assign w_misalign    = 1'b0;
   assign misalign_trap = 1'b0;
`endif

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_is_mem) w_state_next = w_misalign ? DONE : BUSY;
         BUSY:    if (mem_ack) w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Decoded from state so an asynchronous reset drops the request at once.
   assign stall      = w_is_mem & (r_state != DONE);
   assign mem_req    = (r_state == BUSY);
   assign load_valid = (r_state == DONE) & r_is_load & ~r_trap;
   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_be     = r_mem_be;
   assign mem_wdata  = r_mem_wdata;
   assign load_data  = r_load_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_mem_addr  <= '0;
         r_mem_we    <= 1'b0;
         r_mem_be    <= '0;
         r_mem_wdata <= '0;
         r_off       <= 2'd0;
         r_func3     <= 3'd0;
         r_is_load   <= 1'b0;
         r_trap      <= 1'b0;
         r_load_data <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == IDLE && w_is_mem) begin
            r_mem_addr  <= {addr[WIDTH-1:2], 2'b00};
            r_mem_we    <= w_is_store & ~w_misalign;
            r_mem_be    <= w_be;
            r_mem_wdata <= w_wdata;
            r_off       <= addr[1:0];
            r_func3     <= func3;
            r_is_load   <= w_is_load;
            r_trap      <= w_misalign;
         end
         if (r_state == BUSY && mem_ack && r_is_load)
            r_load_data <= fmt_load(mem_rdata, r_off, r_func3);
      end
   end

endmodule
